// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Green-phase scheduler for a 4-approach intersection. Grants right-of-way
//   round-robin among approaches with demand, sizes each green from the queue
//   sensors and sequences GREEN -> YELLOW -> all-red CLEAR.
// Ports
//   clk                      system clock, rising edge
//   rst_n                    asynchronous active-low reset
//   i_sensor_N_1 (N=1..4)    vehicle present at queue position 1 of approach N
//   i_sensor_N_5 (N=1..4)    vehicle present at queue position 5 (long queue)
//   o_green[3:0]             one-hot green lamp, bit N-1 = approach N
//   o_yellow[3:0]            one-hot yellow lamp, bit N-1 = approach N
//   o_red[3:0]               red lamps, always ~(o_green | o_yellow)
//   o_phase_done             one-cycle pulse on the last CLEAR cycle
module traffic_phase_scheduler #(
  parameter int unsigned T_SHORT  = 20,
  parameter int unsigned T_LONG   = 50,
  parameter int unsigned T_YELLOW = 5,
  parameter int unsigned T_CLEAR  = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sensor_1_1,
  input  logic       i_sensor_1_5,
  input  logic       i_sensor_2_1,
  input  logic       i_sensor_2_5,
  input  logic       i_sensor_3_1,
  input  logic       i_sensor_3_5,
  input  logic       i_sensor_4_1,
  input  logic       i_sensor_4_5,
  output logic [3:0] o_green,
  output logic [3:0] o_yellow,
  output logic [3:0] o_red,
  output logic       o_phase_done
);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, CLEAR} state_t;

  localparam logic [CNT_W-1:0] LD_SHORT  = CNT_W'(T_SHORT - 1);
  localparam logic [CNT_W-1:0] LD_LONG   = CNT_W'(T_LONG - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR  = CNT_W'(T_CLEAR - 1);

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx, next_app;
  logic [CNT_W-1:0] timer, timer_nx;
  logic [3:0]       dem, lng;
  logic             any_dem, others_dem;
  logic [3:0]       green_nx, yellow_nx;
  logic             done_nx;

  assign lng     = {i_sensor_4_5, i_sensor_3_5, i_sensor_2_5, i_sensor_1_5};
  assign dem     = {i_sensor_4_1, i_sensor_3_1, i_sensor_2_1, i_sensor_1_1} | lng;
  assign any_dem = |dem;
  assign others_dem = |(dem & ~(4'b0001 << ptr));

  // Round-robin search ptr+1, ptr+2, ptr+3, ptr; the fourth step wraps back
  // to the last served approach so a lone requester is re-granted.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    next_app = ptr;
    found    = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && dem[idx]) begin
        next_app = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    timer_nx = timer;
    case (state)
      IDLE: begin
        if (any_dem) begin
          state_nx = GREEN;
          ptr_nx   = next_app;
          timer_nx = lng[next_app] ? LD_LONG : LD_SHORT;
        end
      end
      GREEN: begin
        if (timer != '0) begin
          timer_nx = timer - CNT_W'(1);
        end else if (dem[ptr] && !others_dem) begin
          // Sole requester keeps the green; duration re-sampled now.
          timer_nx = lng[ptr] ? LD_LONG : LD_SHORT;
        end else begin
          state_nx = YELLOW;
          timer_nx = LD_YELLOW;
        end
      end
      YELLOW: begin
        if (timer != '0) begin
          timer_nx = timer - CNT_W'(1);
        end else begin
          state_nx = CLEAR;
          timer_nx = LD_CLEAR;
        end
      end
      CLEAR: begin
        if (timer != '0) begin
          timer_nx = timer - CNT_W'(1);
        end else if (any_dem) begin
          state_nx = GREEN;
          ptr_nx   = next_app;
          timer_nx = lng[next_app] ? LD_LONG : LD_SHORT;
        end else begin
          state_nx = IDLE;
          timer_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Lamps are registered from the next state so they align with state.
  always_comb begin
    green_nx  = (state_nx == GREEN)  ? (4'b0001 << ptr_nx) : '0;
    yellow_nx = (state_nx == YELLOW) ? (4'b0001 << ptr_nx) : '0;
    done_nx   = (state_nx == CLEAR) && (timer_nx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 2'd3;
      timer        <= '0;
      o_green      <= '0;
      o_yellow     <= '0;
      o_red        <= '1;
      o_phase_done <= 1'b0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      timer        <= timer_nx;
      o_green      <= green_nx;
      o_yellow     <= yellow_nx;
      o_red        <= ~(green_nx | yellow_nx);
      o_phase_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s11 = 0, s15 = 0, s21 = 0, s25 = 0, s31 = 0, s35 = 0, s41 = 0, s45 = 0;
  logic [3:0] o_green, o_yellow, o_red;
  logic       o_phase_done;

  int total = 0;
  int passed = 0;

  logic [3:0] gr [0:511];
  logic [3:0] ye [0:511];
  logic [3:0] rd [0:511];
  logic       pd [0:511];

  traffic_phase_scheduler #(
    .T_SHORT(20), .T_LONG(50), .T_YELLOW(5), .T_CLEAR(2), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sensor_1_1(s11), .i_sensor_1_5(s15),
    .i_sensor_2_1(s21), .i_sensor_2_5(s25),
    .i_sensor_3_1(s31), .i_sensor_3_5(s35),
    .i_sensor_4_1(s41), .i_sensor_4_5(s45),
    .o_green(o_green), .o_yellow(o_yellow), .o_red(o_red),
    .o_phase_done(o_phase_done)
  );

  always #5 clk = ~clk;

  // Lamp invariants every cycle.
  always @(negedge clk) begin
    total++;
    if (!$onehot0(o_green | o_yellow) || (o_red !== ~(o_green | o_yellow)))
      $display("FAIL invariant t=%0t: green=%b yellow=%b red=%b", $time, o_green, o_yellow, o_red);
    else
      passed++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  task automatic set_sensors(input logic [7:0] v);
    {s45, s41, s35, s31, s25, s21, s15, s11} = v;
  endtask

  task automatic apply_reset();
    set_sensors(8'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic record(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gr[start+i] = o_green;
      ye[start+i] = o_yellow;
      rd[start+i] = o_red;
      pd[start+i] = o_phase_done;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (o_red !== 4'hF || o_green !== 4'h0 || o_yellow !== 4'h0 || o_phase_done !== 1'b0)
      $display("FAIL reset_state: red=%h green=%h yellow=%h done=%b, expected F 0 0 0",
               o_red, o_green, o_yellow, o_phase_done);
    else passed++;
  endtask

  task automatic test_all_long();
    int idx [8]        = '{0, 49, 50, 55, 57, 114, 171, 228};
    logic [3:0] eg [8] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] ey [8] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    int npd = 0;
    apply_reset();
    set_sensors(8'hFF);
    record(0, 229);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (gr[idx[k]] !== eg[k] || ye[idx[k]] !== ey[k])
        $display("FAIL all_long[%0d]: green=%h yellow=%h, expected %h %h",
                 idx[k], gr[idx[k]], ye[idx[k]], eg[k], ey[k]);
      else passed++;
    end
    for (int i = 0; i < 229; i++) npd += int'(pd[i]);
    total++;
    if (npd !== 4 || pd[56] !== 1'b1 || pd[55] !== 1'b0 || pd[113] !== 1'b1)
      $display("FAIL all_long_done: count=%0d pd55=%b pd56=%b pd113=%b, expected 4 0 1 1",
               npd, pd[55], pd[56], pd[113]);
    else passed++;
  endtask

  task automatic test_long_drop();
    int idx [11]        = '{0, 49, 50, 57, 76, 77, 84, 111, 138, 157, 158};
    logic [3:0] eg [11] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h8, 4'h1, 4'h1, 4'h0};
    logic [3:0] ey [11] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    apply_reset();
    set_sensors(8'b0101_0111);
    record(0, 100);
    s15 = 1'b0;
    record(100, 60);
    for (int k = 0; k < 11; k++) begin
      total++;
      if (gr[idx[k]] !== eg[k] || ye[idx[k]] !== ey[k])
        $display("FAIL long_drop[%0d]: green=%h yellow=%h, expected %h %h",
                 idx[k], gr[idx[k]], ye[idx[k]], eg[k], ey[k]);
      else passed++;
    end
  endtask

  task automatic test_skip();
    int idx [8]        = '{0, 56, 57, 113, 114, 163, 164, 171};
    logic [3:0] eg [8] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    logic [3:0] ey [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
    int n3 = 0;
    apply_reset();
    set_sensors(8'b1100_1111);
    record(0, 200);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (gr[idx[k]] !== eg[k] || ye[idx[k]] !== ey[k])
        $display("FAIL skip[%0d]: green=%h yellow=%h, expected %h %h",
                 idx[k], gr[idx[k]], ye[idx[k]], eg[k], ey[k]);
      else passed++;
    end
    for (int i = 0; i < 200; i++) n3 += int'(gr[i][2] | ye[i][2]);
    total++;
    if (n3 !== 0) $display("FAIL skip_app3: lit cycles=%0d, expected 0", n3);
    else passed++;
  endtask

  task automatic test_extend();
    int idx [10]        = '{0, 19, 20, 40, 59, 60, 64, 65, 66, 67};
    logic [3:0] eg [10] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
    logic [3:0] ey [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
    int bad = 0;
    apply_reset();
    set_sensors(8'b0000_0100);
    record(0, 46);
    s41 = 1'b1;
    record(46, 30);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (gr[idx[k]] !== eg[k] || ye[idx[k]] !== ey[k])
        $display("FAIL extend[%0d]: green=%h yellow=%h, expected %h %h",
                 idx[k], gr[idx[k]], ye[idx[k]], eg[k], ey[k]);
      else passed++;
    end
    for (int i = 0; i < 60; i++) bad += int'(gr[i] !== 4'h2);
    total++;
    if (bad !== 0 || pd[66] !== 1'b1 || pd[65] !== 1'b0)
      $display("FAIL extend_steady: non-green=%0d pd65=%b pd66=%b, expected 0 0 1",
               bad, pd[65], pd[66]);
    else passed++;
  endtask

  task automatic test_idle_wake();
    int bad = 0;
    apply_reset();
    record(0, 30);
    for (int i = 0; i < 30; i++) bad += int'(rd[i] !== 4'hF || gr[i] !== 4'h0 || pd[i] !== 1'b0);
    total++;
    if (bad !== 0) $display("FAIL idle_hold: bad cycles=%0d, expected 0", bad);
    else passed++;
    s11 = 1'b1;
    record(0, 2);
    total++;
    if (gr[0] !== 4'h1 || gr[1] !== 4'h1)
      $display("FAIL idle_wake: green=%h,%h, expected 1,1", gr[0], gr[1]);
    else passed++;
  endtask

  task automatic test_reset_mid_yellow();
    apply_reset();
    set_sensors(8'hFF);
    record(0, 109);
    total++;
    if (ye[108] !== 4'h2) $display("FAIL pre_reset_yellow: yellow=%h, expected 2", ye[108]);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_red !== 4'hF || o_yellow !== 4'h0 || o_green !== 4'h0)
      $display("FAIL async_reset: red=%h yellow=%h green=%h, expected F 0 0",
               o_red, o_yellow, o_green);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    record(0, 2);
    total++;
    if (gr[0] !== 4'h1) $display("FAIL reset_restart: green=%h, expected 1", gr[0]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_all_long();
    test_long_drop();
    test_skip();
    test_extend();
    test_idle_wake();
    test_reset_mid_yellow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
